data_mem_mask_reader: RTL and testbench
=======================================

// Module: data_mem_mask_reader
// PURPOSE
// - Avalon-MM read master for the 8-bit x 1024 single-port on-chip mask/data RAMs (fixed read latency, no waitrequest).
// - On start, reads LENGTH consecutive bytes from BASE_ADDR and emits them in order as an Avalon-ST byte stream with backpressure.
// - Sits between the RAM's s1 slave and the pixel/sprite pipeline; it is the consumer side of the RAM's read port.
// PARAMETERS
// - ADDR_W        10  RAM word-address width; depth = 2**ADDR_W.
// - DATA_W        8   RAM/stream data width.
// - READ_LATENCY  1   Cycles from address/chipselect to valid avm_readdata (1 = registered address, unregistered q).
// - FIFO_DEPTH    4   Output skid FIFO entries; must be >= READ_LATENCY+1 and a power of 2.
// PORTS
// - clk             in   1         System clock.
// - reset           in   1         Asynchronous, active-high reset.
// - start           in   1         1-cycle request; sampled only in IDLE.
// - base_addr       in   ADDR_W    First word address; captured on start.
// - length          in   ADDR_W+1  Byte count, 0..2**ADDR_W; captured on start.
// - busy            out  1         High from the cycle after an accepted start until done.
// - done            out  1         1-cycle pulse after the final beat is accepted (or after start with length 0).
// - avm_address     out  ADDR_W    Read address to the RAM.
// - avm_chipselect  out  1         High on each issued read.
// - avm_clken       out  1         RAM clock enable; tied high outside reset.
// - avm_write       out  1         Constant 0; master is read-only.
// - avm_readdata    in   DATA_W    RAM read data, valid READ_LATENCY cycles after issue.
// - src_data        out  DATA_W    Stream data (head of the FIFO).
// - src_valid       out  1         Stream valid.
// - src_ready       in   1         Stream ready; a beat transfers when src_valid & src_ready.
// - src_sop         out  1         High on the first beat of a transfer.
// - src_eop         out  1         High on the last beat of a transfer.
// BEHAVIOUR
// - Reset: all outputs 0 except avm_clken (0 while reset is asserted, 1 in the first cycle after release); FIFO emptied, in-flight pipe cleared, FSM in IDLE.
// - FSM: IDLE -> ISSUE on start with length != 0; IDLE -> DONE on start with length == 0; ISSUE -> DRAIN once all length reads are issued;
//   DRAIN -> DONE once the pipe and FIFO are empty and the eop beat is accepted; DONE -> IDLE unconditionally (done=1 for that cycle).
// - start outside IDLE is ignored, with no effect on the transfer in progress.
// - Issue rule (credit based, since the RAM cannot stall): a read is issued in a cycle when the FSM is in ISSUE, remaining != 0 and fifo_count + inflight < FIFO_DEPTH.
//   That cycle drives avm_chipselect=1 and avm_address=cur_addr. After each issue, cur_addr increments and remaining decrements.
// - Addresses wrap modulo 2**ADDR_W: base 1020 with length 8 reads 1020..1023 then 0..3.
// - In-flight tracking: a READ_LATENCY-deep valid shift register. When a valid bit emerges, avm_readdata is written to the FIFO in that cycle.
//   The credit rule guarantees the FIFO never overflows; an overflow is an assertion failure.
// - Throughput: with src_ready held high, 1 beat/cycle. The first src_valid appears READ_LATENCY+1 cycles after the start cycle.
// - FIFO read and write in the same cycle are both honoured (count unchanged). src_data comes from a registered FIFO head.
// - src_sop marks the beat with index 0; src_eop marks index length-1. Both are high on the same beat when length == 1.
//   Tag bits are computed from a beat counter at FIFO write time and stored alongside the data.
// - src_valid deasserted mid-stream with src_ready low: data, sop and eop are held stable until accepted (Avalon-ST rules).
// - Reset asserted mid-transfer: the transfer aborts immediately and no done pulse is produced. In-flight RAM data arriving after reset release is discarded.
// STRUCTURE
// - Package data_mem_pkg: ADDR_W/DATA_W defaults and the mask_rd_state_e enum (IDLE, ISSUE, DRAIN, DONE).
// - Sub-module mask_reader_fifo: synchronous FIFO, width DATA_W+2 (data, sop, eop), depth FIFO_DEPTH, with count output and an overflow assertion.
// - Top module holds the FSM, address/remaining counters, the latency pipe and the credit compare.
// TESTING
// - Bench uses a behavioural 1024x8 RAM model with latency READ_LATENCY, preloaded with mem[i] = i[7:0] ^ 8'hA5.
// - Basic: base=0, len=16, ready=1 -> 16 beats 8'hA5,8'hA4,... back-to-back; sop on beat 0, eop on beat 15; done 1 cycle after beat 15; busy low afterward.
// - Wrap: base=1022, len=4 -> avm_address sequence 1022,1023,0,1; data 8'h5B,8'h5A,8'hA5,8'hA4.
// - Backpressure: base=100, len=32, src_ready random 30% -> no lost or duplicated bytes, fifo_count never exceeds 4, data stable while stalled.
// - Edges: len=1 -> a single beat with sop=eop=1; len=0 -> no chipselect, done pulse the cycle after start; len=1024 -> every address read once.
// - Reset mid-transfer: reset at beat 5 of len=64 -> all outputs 0 and no done pulse; a following start with base=0, len=2 completes cleanly.
// - start pulsed while busy -> ignored; address sequence and beat count of the current transfer unchanged.

Source files
------------

// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the mask/data RAM read master:
//   ADDR_W_DEF / DATA_W_DEF  default RAM geometry (8-bit x 1024)
//   mask_rd_state_e          transfer FSM states
// -----------------------------------------------------------------------------
package data_mem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mask_rd_state_e;

endpackage : data_mem_pkg

// File: rtl/data_mem_mask_reader_if.sv
// -----------------------------------------------------------------------------
// data_mem_mask_reader_if
// Bus bundle for the mask reader: the Avalon-MM read port towards the RAM s1
// slave and the Avalon-ST byte stream towards the pixel/sprite pipeline.
//   master modport : the reader (drives avm_* requests and src_* stream)
//   slave  modport : the environment (RAM read data and stream ready)
// -----------------------------------------------------------------------------
interface data_mem_mask_reader_if
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // Avalon-MM read side
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_clken;
  logic              avm_write;
  logic [DATA_W-1:0] avm_readdata;

  // Avalon-ST source side
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;

  modport master (
    output avm_address, avm_chipselect, avm_clken, avm_write,
    input  avm_readdata,
    output src_data, src_valid, src_sop, src_eop,
    input  src_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_clken, avm_write,
    output avm_readdata,
    input  src_data, src_valid, src_sop, src_eop,
    output src_ready
  );

endinterface : data_mem_mask_reader_if

// File: rtl/data_mem_mask_reader_fifo.sv
// -----------------------------------------------------------------------------
// mask_reader_fifo
// Small synchronous FIFO holding {data, sop, eop} beats for the output stream.
// Simultaneous read and write are both honoured. The head entry is presented
// combinationally from the storage registers.
//   clk, reset   clock, asynchronous active-high reset
//   wr_en_i      push wr_data_i (must not be asserted when full)
//   wr_data_i    entry to push
//   rd_en_i      pop the head entry (ignored when empty)
//   rd_data_o    head entry
//   valid_o      FIFO not empty
//   count_o      number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module mask_reader_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_rd;

  assign do_rd = rd_en_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en_i, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count_q and
  // the head is masked downstream while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // The upstream credit scheme must never push into a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(wr_en_i && !do_rd && (count_q == CNT_W'(DEPTH))));
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;

endmodule : mask_reader_fifo

// File: rtl/data_mem_mask_reader.sv
// -----------------------------------------------------------------------------
// data_mem_mask_reader
// Avalon-MM read master for the 8-bit x 1024 mask/data RAMs. On start it reads
// length consecutive bytes from base_addr (wrapping at the top of the RAM) and
// streams them out in order as Avalon-ST beats with sop/eop framing.
//   clk, reset   clock, asynchronous active-high reset
//   start        1-cycle request, only accepted in IDLE
//   base_addr    first word address (captured on start)
//   length       byte count 0..2**ADDR_W (captured on start)
//   busy         transfer in progress (ISSUE or DRAIN)
//   done         1-cycle completion pulse
//   bus          master side of the RAM read port and output stream
// The RAM cannot stall, so reads are only issued while the FIFO has room for
// every byte already in flight (credit = fifo_count + inflight).
// -----------------------------------------------------------------------------
module data_mem_mask_reader
  import data_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      length,
  output logic                 busy,
  output logic                 done,
  data_mem_mask_reader_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  mask_rd_state_e        state_q,     state_d;
  logic [ADDR_W-1:0]     cur_addr_q,  cur_addr_d;
  logic [ADDR_W:0]       remaining_q, remaining_d;
  logic [ADDR_W:0]       len_q,       len_d;
  logic [ADDR_W:0]       wr_idx_q,    wr_idx_d;
  logic [READ_LATENCY-1:0] pipe_q,    pipe_d;
  logic [READ_LATENCY:0]   pipe_ext;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_valid;
  logic [DATA_W+1:0] fifo_head;
  logic [DATA_W+1:0] fifo_wdata;
  logic              fifo_wr;
  logic              pop;
  logic [CNT_W:0]    inflight;
  logic              credit_ok;
  logic              issue;
  logic              last_pop;

  // Reads currently travelling through the RAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + {{CNT_W{1'b0}}, pipe_q[i]};
    end
  end

  assign credit_ok = ({1'b0, fifo_count} + inflight) < (CNT_W + 1)'(FIFO_DEPTH);
  assign issue     = (state_q == ISSUE) && (remaining_q != '0) && credit_ok;

  // A valid bit leaving the pipe means avm_readdata belongs to us this cycle.
  // Framing tags are attached here from the write-side beat index.
  assign fifo_wr    = pipe_q[READ_LATENCY-1];
  assign fifo_wdata = {bus.avm_readdata,
                       (wr_idx_q == '0),
                       (wr_idx_q == len_q - 1'b1)};

  assign pop      = fifo_valid && bus.src_ready;
  // The eop beat is the last entry, so once it leaves nothing else remains.
  assign last_pop = pop && fifo_head[0] && (fifo_count == CNT_W'(1)) && (pipe_q == '0);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    pipe_ext    = {pipe_q, issue};
    pipe_d      = pipe_ext[READ_LATENCY-1:0];

    if (issue) begin
      cur_addr_d  = cur_addr_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end
    if (fifo_wr) wr_idx_d = wr_idx_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_addr_d  = base_addr;
          remaining_d = length;
          len_d       = length;
          wr_idx_d    = '0;
          state_d     = (length == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (issue && (remaining_q == (ADDR_W + 1)'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_pop) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      wr_idx_q    <= '0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      pipe_q      <= pipe_d;
    end
  end

  mask_reader_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .valid_o   (fifo_valid),
    .count_o   (fifo_count)
  );

  assign busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  assign bus.avm_address    = issue ? cur_addr_q : '0;
  assign bus.avm_chipselect = issue;
  assign bus.avm_clken      = ~reset;
  assign bus.avm_write      = 1'b0;

  // Head is masked while empty so the stream idles at zero.
  assign bus.src_valid = fifo_valid;
  assign bus.src_data  = fifo_valid ? fifo_head[DATA_W+1:2] : '0;
  assign bus.src_sop   = fifo_valid & fifo_head[1];
  assign bus.src_eop   = fifo_valid & fifo_head[0];

endmodule : data_mem_mask_reader

// File: tb/tb_data_mem_mask_reader.sv
// -----------------------------------------------------------------------------
// tb_data_mem_mask_reader
// Self-checking bench: a behavioural RAM (mem[i] = i[7:0] ^ 8'hA5) with fixed
// read latency, a negedge monitor collecting issued addresses and accepted
// beats, and a model that derives the expected address/data/tag sequence
// directly from (base + i) mod 1024.
// -----------------------------------------------------------------------------
module tb_data_mem_mask_reader;
  import data_mem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int LAT    = 1;
  localparam int DEPTH  = 4;
  localparam int RAM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;

  data_mem_mask_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_mem_mask_reader #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (LAT),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [DATA_W-1:0] mem [RAM_N];
  logic [DATA_W-1:0] rd_pipe [LAT];

  initial for (int i = 0; i < RAM_N; i++) mem[i] = i[7:0] ^ 8'hA5;

  always @(posedge clk) begin
    if (bus.avm_clken) begin
      // Unselected cycles return a marker value so stray captures show up.
      rd_pipe[0] <= bus.avm_chipselect ? mem[bus.avm_address] : 8'hEE;
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
  end
  assign bus.avm_readdata = rd_pipe[LAT-1];

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    int         cyc;
  } beat_t;

  logic [ADDR_W-1:0] addr_q [$];
  beat_t             beat_q [$];
  int issued, accepted, max_out, stall_err;
  int done_cnt, done_cyc, eop_cyc, first_valid_cyc;
  logic       prev_stall;
  logic [9:0] prev_beat;

  task automatic clear_mon();
    addr_q.delete();
    beat_q.delete();
    issued = 0; accepted = 0; max_out = 0; stall_err = 0;
    done_cnt = 0; done_cyc = -1; eop_cyc = -1; first_valid_cyc = -1;
    prev_stall = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.avm_chipselect) begin
        addr_q.push_back(bus.avm_address);
        issued++;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (prev_stall &&
          (!bus.src_valid || {bus.src_data, bus.src_sop, bus.src_eop} != prev_beat))
        stall_err++;
      if (bus.src_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.src_valid && bus.src_ready) begin
        beat_q.push_back('{bus.src_data, bus.src_sop, bus.src_eop, cyc});
        accepted++;
        if (bus.src_eop) eop_cyc = cyc;
      end
      prev_stall = bus.src_valid && !bus.src_ready;
      prev_beat  = {bus.src_data, bus.src_sop, bus.src_eop};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    int         base;
    int         len;
    int         ready_pct;
    bit         start_busy;
    logic [7:0] exp_first;
  } vec_t;

  vec_t vecs [$];

  // Runs one transfer and compares everything the monitor saw with the model.
  // Entered and left at #1 after a rising edge.
  task automatic run_xfer(input vec_t v);
    int s_cyc, n, mism_a, mism_d, mism_t, lim;
    clear_mon();
    base_addr     = ADDR_W'(v.base);
    length        = (ADDR_W + 1)'(v.len);
    start         = 1'b1;
    bus.src_ready = 1'b1;
    s_cyc         = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), int'(v.len != 0));

    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      bus.src_ready = ($urandom_range(0, 99) < v.ready_pct);
      if (v.start_busy && n == 3) begin
        start = 1'b1; base_addr = 10'd500; length = 11'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (done_cnt == 0) check("done_timeout", 0, 1);

    check("busy_after_done", int'(busy), 0);
    check("idle_valid_after_done", int'(bus.src_valid), 0);

    check("addr_count", addr_q.size(), v.len);
    lim = (addr_q.size() < v.len) ? addr_q.size() : v.len;
    mism_a = 0;
    for (int i = 0; i < lim; i++)
      if (int'(addr_q[i]) != (v.base + i) % RAM_N) mism_a++;
    check("addr_seq_mismatches", mism_a, 0);

    check("beat_count", beat_q.size(), v.len);
    lim = (beat_q.size() < v.len) ? beat_q.size() : v.len;
    mism_d = 0; mism_t = 0;
    for (int i = 0; i < lim; i++) begin
      if (beat_q[i].data != (8'((v.base + i) % RAM_N) ^ 8'hA5)) mism_d++;
      if (beat_q[i].sop != (i == 0) || beat_q[i].eop != (i == v.len - 1)) mism_t++;
    end
    check("data_mismatches", mism_d, 0);
    check("sop_eop_mismatches", mism_t, 0);

    check("done_pulses", done_cnt, 1);
    if (v.len == 0) begin
      check("done_after_zero_len_start", done_cyc - s_cyc, 1);
    end else begin
      check("done_after_eop", done_cyc - eop_cyc, 1);
      check("first_data", int'(beat_q.size() > 0 ? beat_q[0].data : 8'h00), int'(v.exp_first));
      // start sampled on the edge closing cycle s_cyc; the first beat is
      // visible LAT+1 edges after that.
      check("first_valid_latency", first_valid_cyc - s_cyc, LAT + 2);
      if (v.ready_pct >= 100 && beat_q.size() > 0)
        check("back_to_back", beat_q[$].cyc - beat_q[0].cyc, v.len - 1);
    end
    check("stall_stable_errors", stall_err, 0);
    check("outstanding_within_depth", int'(max_out <= DEPTH), 1);
  endtask

  // ---------------- main ----------------
  initial begin
    vec_t v;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; bus.src_ready = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl_outputs",
          int'({bus.avm_chipselect, bus.src_valid, busy, done, bus.src_sop,
                bus.src_eop, bus.avm_clken, bus.avm_write}), 0);
    check("reset_addr_data", int'(bus.avm_address) + int'(bus.src_data), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("clken_after_release", int'(bus.avm_clken), 1);
    check("idle_quiet", int'({bus.avm_chipselect, bus.src_valid, busy, done}), 0);

    // {base, len, ready %, start while busy, expected first byte}
    vecs.push_back('{0,    16,   100, 1'b0, 8'hA5});  // basic
    vecs.push_back('{1022, 4,    100, 1'b0, 8'h5B});  // wrap 1022,1023,0,1
    vecs.push_back('{100,  32,   70,  1'b0, 8'hC1});  // backpressure
    vecs.push_back('{37,   1,    100, 1'b0, 8'h80});  // single beat
    vecs.push_back('{5,    0,    100, 1'b0, 8'h00});  // zero length
    vecs.push_back('{0,    1024, 100, 1'b0, 8'hA5});  // full RAM
    vecs.push_back('{200,  20,   100, 1'b1, 8'h6D});  // start while busy
    vecs.push_back('{1020, 8,    50,  1'b0, 8'h59});  // wrap under stalls
    foreach (vecs[i]) run_xfer(vecs[i]);

    for (int r = 0; r < 4; r++) begin
      v.base       = $urandom_range(0, RAM_N - 1);
      v.len        = $urandom_range(1, 40);
      v.ready_pct  = $urandom_range(20, 100);
      v.start_busy = 1'b0;
      v.exp_first  = 8'(v.base) ^ 8'hA5;
      run_xfer(v);
    end

    // Reset in the middle of a 64-byte transfer, at beat 5.
    clear_mon();
    base_addr = '0; length = 11'd64; start = 1'b1; bus.src_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 200 && accepted < 5; n++) begin
      @(posedge clk); #1;
    end
    check("reached_beat5", int'(accepted >= 5), 1);
    reset = 1'b1;
    #1;
    check("midreset_ctrl_outputs",
          int'({bus.avm_chipselect, bus.src_valid, busy, done, bus.src_sop,
                bus.src_eop, bus.avm_clken, bus.avm_write}), 0);
    check("midreset_addr_data", int'(bus.avm_address) + int'(bus.src_data), 0);
    repeat (2) @(posedge clk);
    #1;
    clear_mon();
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt, 0);
    check("no_beats_after_abort", beat_q.size() + addr_q.size(), 0);
    v = '{0, 2, 100, 1'b0, 8'hA5};
    run_xfer(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_data_mem_mask_reader
